// File: rtl/cronometro_pkg.sv
// Shared state encoding and field widths for the stopwatch control path.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int MS_W    = 10;
  localparam int SEC_W   = 6;
  localparam int LAPC_W  = 4;
  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;

endpackage

// File: rtl/boton_debounce.sv
// Button conditioner: 2-FF sync, stable-level debounce, registered rising-edge pulse.
// Latency DEBOUNCE_CYCLES+3 edges from first raw-high sample to pulse; no backpressure.
module boton_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic             pulse_q;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cronometro_control.sv
// Stopwatch control FSM: button pulses -> counter enable/clear, lap capture, display select.
// Outputs registered with the state (1 edge after a pulse); display mux combinational; no backpressure.
module cronometro_control
  import cronometro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LAP_MAX         = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [MS_W-1:0]   ms_in,
  input  logic [SEC_W-1:0]  sec_in,
  output logic              count_en,
  output logic              count_clr,
  output logic [MS_W-1:0]   disp_ms,
  output logic [SEC_W-1:0]  disp_sec,
  output logic              running,
  output logic              lap_active,
  output logic [LAPC_W-1:0] lap_count
);

  logic ss_p, lr_p;

  boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .pulse   (ss_p)
  );

  boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lr),
    .pulse   (lr_p)
  );

  state_t              state_q, state_d;
  logic                count_en_q, count_en_d;
  logic                count_clr_q, count_clr_d;
  logic                lap_active_q, lap_active_d;
  logic [MS_W-1:0]     lap_ms_q, lap_ms_d;
  logic [SEC_W-1:0]    lap_sec_q, lap_sec_d;
  logic [LAPC_W-1:0]   lap_count_q, lap_count_d;

  // Start/stop has priority: lr_p is only looked at when ss_p is low.
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    lap_ms_d    = lap_ms_q;
    lap_sec_d   = lap_sec_q;
    lap_count_d = lap_count_q;
    case (state_q)
      IDLE: begin
        if (ss_p) begin
          state_d = RUN;
        end else if (lr_p) begin
          count_clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ss_p) begin
          state_d = STOP;
        end else if (lr_p) begin
          state_d   = LAP;
          lap_ms_d  = ms_in;
          lap_sec_d = sec_in;
          if (lap_count_q < LAPC_W'(LAP_MAX)) begin
            lap_count_d = lap_count_q + 1'b1;
          end
        end
      end
      LAP: begin
        if (ss_p) begin
          state_d = STOP;
        end else if (lr_p) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (ss_p) begin
          state_d = RUN;
        end else if (lr_p) begin
          state_d     = IDLE;
          count_clr_d = 1'b1;
          lap_count_d = '0;
          lap_ms_d    = '0;
          lap_sec_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    count_en_d   = (state_d == RUN) || (state_d == LAP);
    lap_active_d = (state_d == LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_en_q   <= 1'b0;
      count_clr_q  <= 1'b0;
      lap_active_q <= 1'b0;
      lap_ms_q     <= '0;
      lap_sec_q    <= '0;
      lap_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_en_q   <= count_en_d;
      count_clr_q  <= count_clr_d;
      lap_active_q <= lap_active_d;
      lap_ms_q     <= lap_ms_d;
      lap_sec_q    <= lap_sec_d;
      lap_count_q  <= lap_count_d;
    end
  end

  assign count_en   = count_en_q;
  assign count_clr  = count_clr_q;
  assign running    = count_en_q;
  assign lap_active = lap_active_q;
  assign lap_count  = lap_count_q;
  assign disp_ms    = lap_active_q ? lap_ms_q  : ms_in;
  assign disp_sec   = lap_active_q ? lap_sec_q : sec_in;

endmodule

// File: tb/tb_cronometro_control.sv
// Directed bench for cronometro_control with a short debounce window.
module tb_cronometro_control;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic [9:0] ms_in;
  logic [5:0] sec_in;
  logic       count_en;
  logic       count_clr;
  logic [9:0] disp_ms;
  logic [5:0] disp_sec;
  logic       running;
  logic       lap_active;
  logic [3:0] lap_count;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_seen = 0;
  int clr_with_en = 0;

  cronometro_control #(
    .DEBOUNCE_CYCLES (4),
    .LAP_MAX         (15)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .ms_in      (ms_in),
    .sec_in     (sec_in),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .disp_ms    (disp_ms),
    .disp_sec   (disp_sec),
    .running    (running),
    .lap_active (lap_active),
    .lap_count  (lap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full press/release: long enough for the FSM to act and the debouncer to settle low.
  task automatic press(input logic ss, input logic lr);
    clr_seen = 0;
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    repeat (9) begin
      @(negedge clk);
      if (count_clr) clr_seen++;
      if (count_clr && count_en) clr_with_en++;
    end
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (count_clr) clr_seen++;
      if (count_clr && count_en) clr_with_en++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    ms_in  = 10'd321;
    sec_in = 6'd45;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({count_en, running, lap_active, count_clr, lap_count} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 00000000", {count_en, running, lap_active, count_clr, lap_count});
    end
    n_cmp++;
    if ({disp_ms, disp_sec} !== {10'd321, 6'd45}) begin
      n_bad++;
      $display("FAIL reset_disp got %0d/%0d want 321/45", disp_ms, disp_sec);
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce_latency();
    @(negedge clk);
    btn_ss = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 7) begin
        n_cmp++;
        if (count_en !== 1'b0) begin
          n_bad++;
          $display("FAIL latency_early count_en got %b want 0 at edge 7", count_en);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if ({count_en, running, lap_active} !== 3'b110) begin
          n_bad++;
          $display("FAIL latency_run got %b want 110 at edge 8", {count_en, running, lap_active});
        end
      end
    end
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (count_en !== 1'b1) begin
      n_bad++;
      $display("FAIL release_no_pulse count_en got %b want 1", count_en);
    end
    // 3-cycle glitch must be filtered: still running afterwards
    btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (count_en !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_filtered count_en got %b want 1", count_en);
    end
  endtask

  task automatic test_lap_capture();
    @(negedge clk);
    btn_lr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        n_cmp++;
        if ({disp_ms, disp_sec} !== {10'd437, 6'd12}) begin
          n_bad++;
          $display("FAIL lap_disp got %0d/%0d want 437/12", disp_ms, disp_sec);
        end
        n_cmp++;
        if ({count_en, lap_active, lap_count} !== 6'b11_0001) begin
          n_bad++;
          $display("FAIL lap_flags got %b want 110001", {count_en, lap_active, lap_count});
        end
      end
      // value presented just before the pulse edge (edge 8) is 437/12
      ms_in  = 10'(430 + k);
      sec_in = 6'(5 + k);
    end
    btn_lr = 1'b0;
    repeat (8) @(negedge clk);
    press(1'b0, 1'b1);
    ms_in  = 10'd777;
    sec_in = 6'd33;
    #1;
    n_cmp++;
    if ({disp_ms, disp_sec} !== {10'd777, 6'd33}) begin
      n_bad++;
      $display("FAIL lap_release_disp got %0d/%0d want 777/33", disp_ms, disp_sec);
    end
    n_cmp++;
    if ({count_en, lap_active, lap_count} !== 6'b10_0001) begin
      n_bad++;
      $display("FAIL lap_release_flags got %b want 100001", {count_en, lap_active, lap_count});
    end
  endtask

  task automatic test_lap_saturation();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd1;
    for (int i = 0; i < 16; i++) begin
      press(1'b0, 1'b1);
      if (exp_cnt < 4'd15) exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if ({lap_active, lap_count} !== {1'b1, exp_cnt}) begin
        n_bad++;
        $display("FAIL lap_sat_%0d got active=%b cnt=%0d want active=1 cnt=%0d", i, lap_active, lap_count, exp_cnt);
      end
      press(1'b0, 1'b1);
    end
    n_cmp++;
    if ({count_en, lap_active, lap_count} !== 6'b10_1111) begin
      n_bad++;
      $display("FAIL lap_sat_final got %b want 101111", {count_en, lap_active, lap_count});
    end
  endtask

  task automatic test_stop_resume_clear();
    clr_with_en = 0;
    press(1'b1, 1'b0);
    n_cmp++;
    if ({count_en, running} !== 2'b00) begin
      n_bad++;
      $display("FAIL stop got %b want 00", {count_en, running});
    end
    press(1'b1, 1'b0);
    n_cmp++;
    if ({count_en, clr_seen[1:0]} !== 3'b100) begin
      n_bad++;
      $display("FAIL resume got en=%b clr_cycles=%0d want en=1 clr_cycles=0", count_en, clr_seen);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_cmp++;
    if (clr_seen !== 1) begin
      n_bad++;
      $display("FAIL clear_pulse_width got %0d cycles want 1", clr_seen);
    end
    n_cmp++;
    if ({count_en, lap_active, count_clr, lap_count} !== 7'b000_0000) begin
      n_bad++;
      $display("FAIL clear_state got %b want 0000000", {count_en, lap_active, count_clr, lap_count});
    end
    ms_in  = 10'd123;
    sec_in = 6'd7;
    #1;
    n_cmp++;
    if ({disp_ms, disp_sec} !== {10'd123, 6'd7}) begin
      n_bad++;
      $display("FAIL clear_disp got %0d/%0d want 123/7", disp_ms, disp_sec);
    end
    n_cmp++;
    if (clr_with_en !== 0) begin
      n_bad++;
      $display("FAIL clr_with_en got %0d want 0", clr_with_en);
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    n_cmp++;
    if ({count_en, lap_active, lap_count} !== 6'b10_0001) begin
      n_bad++;
      $display("FAIL simul_setup got %b want 100001", {count_en, lap_active, lap_count});
    end
    press(1'b1, 1'b1);
    n_cmp++;
    if ({count_en, lap_active, lap_count} !== 6'b00_0001) begin
      n_bad++;
      $display("FAIL simul_both got %b want 000001", {count_en, lap_active, lap_count});
    end
    n_cmp++;
    if (clr_seen !== 0) begin
      n_bad++;
      $display("FAIL simul_no_clr got %0d want 0", clr_seen);
    end
  endtask

  task automatic test_reset_mid_op();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_cmp++;
    if ({lap_active, lap_count} !== 5'b1_0010) begin
      n_bad++;
      $display("FAIL midrst_setup got %b want 10010", {lap_active, lap_count});
    end
    btn_lr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({count_en, running, lap_active, count_clr, lap_count} !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_outputs got %b want 00000000", {count_en, running, lap_active, count_clr, lap_count});
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 7 && count_clr !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL midrst_early_clr got 1 want 0 at edge %0d", k);
      end
      if (k == 8) begin
        n_cmp++;
        if ({count_clr, count_en, lap_active} !== 3'b100) begin
          n_bad++;
          $display("FAIL midrst_clr got %b want 100 at edge 8", {count_clr, count_en, lap_active});
        end
      end
      if (k == 9) begin
        n_cmp++;
        if ({count_clr, count_en} !== 2'b00) begin
          n_bad++;
          $display("FAIL midrst_clr_end got %b want 00 at edge 9", {count_clr, count_en});
        end
      end
    end
    btn_lr = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_lap_capture();
    test_lap_saturation();
    test_stop_resume_clear();
    test_simultaneous();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
